// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, absorbs the one-cycle memory read latency
// and feeds decode through a 2-entry valid/ready buffer. Optional FETCH_PERF_CNT_EN adds perf counters.
module fetch_unit #(
    parameter int ASIZE = 16,
    parameter int DSIZE = 16,
    parameter logic [ASIZE-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    output logic [ASIZE-1:0] mem_addr,
    input  logic [DSIZE-1:0] mem_rdata,
    input  logic             halt,
    input  logic             redirect_valid,
    input  logic [ASIZE-1:0] redirect_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DSIZE-1:0] out_instr,
    output logic [ASIZE-1:0] out_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]      perf_fetched,
    output logic [15:0]      perf_stall
`endif
);

    localparam logic [ASIZE-1:0] PC_ONE = 1;

    logic [ASIZE-1:0] pc;
    logic [ASIZE-1:0] inflight_pc;
    logic             inflight;
    logic [1:0]       count;
    logic [ASIZE-1:0] pc0, pc1;
    logic [DSIZE-1:0] ins0, ins1;
    logic [2:0]       occupancy;
    logic             deq;
    logic             issue;
    logic             push;

    assign mem_addr  = pc;
    assign out_valid = (count != 2'd0);
    assign out_pc    = pc0;
    assign out_instr = ins0;

    // Queued entries plus the outstanding fetch must never exceed the buffer depth.
    assign occupancy = {1'b0, count} + {2'b00, inflight};
    assign deq       = out_valid && out_ready;
    assign issue     = !rst && !halt && !redirect_valid && ((occupancy < 3'd2) || deq);
    assign push      = inflight && !redirect_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            if (redirect_valid)
                pc <= redirect_pc;
            else if (issue)
                pc <= pc + PC_ONE;
            inflight <= issue;
            if (issue)
                inflight_pc <= pc;
        end
    end

    // Slot 0 is always the head; a dequeue shifts slot 1 down.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 2'd0;
            pc0   <= '0;
            pc1   <= '0;
            ins0  <= '0;
            ins1  <= '0;
        end else if (redirect_valid) begin
            count <= 2'd0;
        end else begin
            case ({push, deq})
                2'b10: begin
                    if (count == 2'd0) begin
                        pc0  <= inflight_pc;
                        ins0 <= mem_rdata;
                    end else begin
                        pc1  <= inflight_pc;
                        ins1 <= mem_rdata;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    pc0   <= pc1;
                    ins0  <= ins1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        pc0  <= inflight_pc;
                        ins0 <= mem_rdata;
                    end else begin
                        pc0  <= pc1;
                        ins0 <= ins1;
                        pc1  <= inflight_pc;
                        ins1 <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic stall_cycle;
    assign stall_cycle = !rst && !halt && !redirect_valid && !issue;

    // Both counters saturate rather than wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched <= 16'd0;
            perf_stall   <= 16'd0;
        end else begin
            if (push && perf_fetched != 16'hFFFF)
                perf_fetched <= perf_fetched + 16'd1;
            if (stall_cycle && perf_stall != 16'hFFFF)
                perf_stall <= perf_stall + 16'd1;
        end
    end
`else
    // No performance counters in this build.
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        halt = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'd0;
    logic        out_ready = 1'b0;

    logic [15:0] mem_addr, mem_rdata, out_instr, out_pc;
    logic        out_valid;
    logic [15:0] mem_addr2, mem_rdata2, out_instr2, out_pc2;
    logic        out_valid2;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] perf_fetched, perf_stall, perf_fetched2, perf_stall2;
`endif

    int checkCount = 0;
    int passCount  = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .halt(halt), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
    );

    fetch_unit #(.RESET_PC(16'hFFFE)) dut2 (
        .clk(clk), .rst(rst), .mem_addr(mem_addr2), .mem_rdata(mem_rdata2),
        .halt(halt), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid2), .out_ready(out_ready), .out_instr(out_instr2), .out_pc(out_pc2)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetched(perf_fetched2), .perf_stall(perf_stall2)
`endif
    );

    // Program memory image as a pure function of the address.
    function automatic logic [15:0] memWord(input logic [15:0] a);
        if (a < 16'd4)
            return (a + 16'd1) * 16'h1111;
        return (a * 16'h9E37) ^ 16'h1234;
    endfunction

    always @(posedge clk) begin
        mem_rdata  <= memWord(mem_addr);
        mem_rdata2 <= memWord(mem_addr2);
    end

    always @(negedge clk) begin
        assert (dut.count <= 2'd2);
    end

    // Reference model: architectural PC, one outstanding fetch, FIFO as a queue of {pc, instr}.
    logic [15:0] mPc = 16'd0;
    logic [15:0] mIpc = 16'd0;
    bit          mInfl = 1'b0;
    logic [31:0] mQ[$];
    bit          mInReset = 1'b1;
    logic [15:0] mFetched = 16'd0;
    logic [15:0] mStall = 16'd0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs === exp)
            passCount++;
        else
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    endtask

    task automatic modelStep(input bit r, input bit h, input bit rv, input logic [15:0] rpc, input bit rdy);
        bit deq, issue, push;
        if (r) begin
            mPc = 16'd0;
            mInfl = 1'b0;
            mQ.delete();
            mFetched = 16'd0;
            mStall = 16'd0;
            mInReset = 1'b1;
            return;
        end
        mInReset = 1'b0;
        deq   = (mQ.size() != 0) && rdy;
        issue = !h && !rv && (((mQ.size() + int'(mInfl)) < 2) || deq);
        push  = mInfl && !rv;
        if (deq)
            void'(mQ.pop_front());
        if (rv) begin
            mQ.delete();
            mPc = rpc;
        end else if (push) begin
            mQ.push_back({mIpc, memWord(mIpc)});
        end
        if (push && mFetched != 16'hFFFF)
            mFetched++;
        if (!h && !rv && !issue && mStall != 16'hFFFF)
            mStall++;
        mInfl = issue;
        if (issue) begin
            mIpc = mPc;
            mPc  = mPc + 16'd1;
        end
    endtask

    task automatic applyStimulus(input bit r, input bit h, input bit rv, input logic [15:0] rpc, input bit rdy);
        logic [31:0] head;
        @(negedge clk);
        rst = r;
        halt = h;
        redirect_valid = rv;
        redirect_pc = rpc;
        out_ready = rdy;
        modelStep(r, h, rv, rpc, rdy);
        @(posedge clk);
        #1;
        checkOutput("out_valid", {31'd0, out_valid}, {31'd0, mQ.size() != 0});
        checkOutput("mem_addr", {16'd0, mem_addr}, {16'd0, mPc});
        if (mQ.size() != 0) begin
            head = mQ[0];
            checkOutput("out_pc", {16'd0, out_pc}, {16'd0, head[31:16]});
            checkOutput("out_instr", {16'd0, out_instr}, {16'd0, head[15:0]});
        end else if (mInReset) begin
            checkOutput("reset_out_pc", {16'd0, out_pc}, 32'd0);
            checkOutput("reset_out_instr", {16'd0, out_instr}, 32'd0);
        end
`ifdef FETCH_PERF_CNT_EN
        checkOutput("perf_fetched", {16'd0, perf_fetched}, {16'd0, mFetched});
        checkOutput("perf_stall", {16'd0, perf_stall}, {16'd0, mStall});
`endif
    endtask

    initial begin
        bit found;
        logic [15:0] expPc;

        // Reset state, including the FFFE-reset instance.
        repeat (3) applyStimulus(1, 0, 0, 16'd0, 1);
        checkOutput("dut2_reset_addr", {16'd0, mem_addr2}, 32'h0000FFFE);
        checkOutput("dut2_reset_valid", {31'd0, out_valid2}, 32'd0);

        // Reset release with decode always ready: PCs 0..3, and FFFE.. on the second instance.
        applyStimulus(0, 0, 0, 16'd0, 1);
        checkOutput("first_valid_latency", {31'd0, out_valid}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 0, 0, 16'd0, 1);
            checkOutput("stream_pc", {16'd0, out_pc}, k);
            checkOutput("stream_instr", {16'd0, out_instr}, (k + 1) * 32'h1111);
            expPc = 16'hFFFE + 16'(k);
            checkOutput("wrap_pc", {16'd0, out_pc2}, {16'd0, expPc});
            checkOutput("wrap_instr", {16'd0, out_instr2}, {16'd0, memWord(expPc)});
        end

        // Backpressure: two buffered entries, then drain back-to-back.
        repeat (2) applyStimulus(1, 0, 0, 16'd0, 0);
        repeat (6) applyStimulus(0, 0, 0, 16'd0, 0);
        checkOutput("bp_head", {16'd0, out_pc}, 32'd0);
        checkOutput("bp_addr", {16'd0, mem_addr}, 32'd2);
        for (int k = 1; k < 4; k++) begin
            applyStimulus(0, 0, 0, 16'd0, 1);
            checkOutput("bp_drain_pc", {16'd0, out_pc}, k);
        end

        // Redirect to 0x0040 while PC 2 is being dequeued.
        repeat (2) applyStimulus(1, 0, 0, 16'd0, 1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (out_valid && out_pc == 16'd2)
                found = 1'b1;
            else
                applyStimulus(0, 0, 0, 16'd0, 1);
        end
        checkOutput("redirect_wait", {31'd0, found}, 32'd1);
        applyStimulus(0, 0, 1, 16'h0040, 1);
        checkOutput("redirect_flush", {31'd0, out_valid}, 32'd0);
        checkOutput("redirect_addr", {16'd0, mem_addr}, 32'h0040);
        applyStimulus(0, 0, 0, 16'd0, 1);
        applyStimulus(0, 0, 0, 16'd0, 1);
        checkOutput("redirect_target_pc", {16'd0, out_pc}, 32'h0040);
        checkOutput("redirect_target_instr", {16'd0, out_instr}, {16'd0, memWord(16'h0040)});

        // Halt for three cycles mid-stream.
        applyStimulus(0, 0, 0, 16'd0, 1);
        applyStimulus(0, 1, 0, 16'd0, 1);
        checkOutput("halt_inflight_lands", {31'd0, out_valid}, 32'd1);
        applyStimulus(0, 1, 0, 16'd0, 1);
        checkOutput("halt_drained", {31'd0, out_valid}, 32'd0);
        applyStimulus(0, 1, 0, 16'd0, 1);
        repeat (4) applyStimulus(0, 0, 0, 16'd0, 1);

        // Reset with two entries queued.
        repeat (2) applyStimulus(1, 0, 0, 16'd0, 0);
        repeat (4) applyStimulus(0, 0, 0, 16'd0, 0);
        applyStimulus(1, 0, 0, 16'd0, 0);
        checkOutput("midrst_flush", {31'd0, out_valid}, 32'd0);
        applyStimulus(0, 0, 0, 16'd0, 1);
        applyStimulus(0, 0, 0, 16'd0, 1);
        checkOutput("midrst_first_pc", {16'd0, out_pc}, 32'd0);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 3000; n++) begin
            bit rr, hh, rv, rdy;
            logic [15:0] tgt;
            rr  = ($urandom_range(0, 199) == 0);
            hh  = ($urandom_range(0, 9) == 0);
            rv  = ($urandom_range(0, 29) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            tgt = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFC + $urandom_range(0, 3)) : 16'($urandom);
            applyStimulus(rr, hh, rv, tgt, rdy);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
